// File: rtl/disp_cmd_decoder_pkg.sv
// Shared opcode values, decoder FSM encodings and operand-count lookup
// for the icevga command path.
package icevga_cmd_pkg;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_SET_BG     = 8'h01;
    localparam logic [7:0] OP_SET_FG     = 8'h02;
    localparam logic [7:0] OP_SET_CURSOR = 8'h03;
    localparam logic [7:0] OP_PUT_CHAR   = 8'h04;
    localparam logic [7:0] OP_NEWLINE    = 8'h0A;

    typedef enum logic [1:0] {
        S_OPCODE = 2'd0,
        S_OPND1  = 2'd1,
        S_OPND2  = 2'd2,
        S_EXEC   = 2'd3
    } state_t;

    // Unknown opcodes take no operands so a bad byte costs only itself.
    function automatic logic [1:0] opnd_count(input logic [7:0] op);
        case (op)
            OP_SET_BG, OP_SET_FG, OP_SET_CURSOR: return 2'd2;
            OP_PUT_CHAR:                         return 2'd1;
            default:                             return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/disp_cmd_decoder_reader.sv
// cmdreg byte reader: one rd pulse per accepted byte, followed by a hold
// cycle while cmdreg updates has_data.
module cmd_byte_reader (
    input  logic       clk,
    input  logic       nrst,
    input  logic       cmd_avail,
    input  logic [7:0] cmd_data,
    input  logic       byte_ready,
    output logic       cmd_rd,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    // cmd_rd is high exactly during the hold cycle, so it doubles as the
    // hold flag and guarantees at most one byte every two clocks.
    assign byte_valid = cmd_avail && !cmd_rd && byte_ready;
    assign byte_data  = cmd_data;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cmd_rd <= 1'b0;
        end else begin
            cmd_rd <= byte_valid;
        end
    end

endmodule

// File: rtl/disp_cmd_decoder.sv
// Display command decoder: parses opcode/operand bytes from cmdreg and
// drives colour, cursor and character-RAM write outputs.
module disp_cmd_decoder
    import icevga_cmd_pkg::*;
#(
    parameter int TEXT_COLS = 100,
    parameter int TEXT_ROWS = 37,
    parameter int ADDR_W    = 12
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cmd_avail,
    input  logic [7:0]        cmd_data,
    output logic              cmd_rd,
    output logic [11:0]       bg_color,
    output logic [11:0]       fg_color,
    output logic [6:0]        cursor_col,
    output logic [5:0]        cursor_row,
    output logic              char_wr,
    output logic [ADDR_W-1:0] char_addr,
    output logic [7:0]        char_data,
    output logic [7:0]        err_count
);

    localparam logic [6:0] LAST_COL = 7'(TEXT_COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(TEXT_ROWS - 1);
    localparam logic [7:0] COLS_B   = 8'(TEXT_COLS);
    localparam logic [7:0] ROWS_B   = 8'(TEXT_ROWS);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t     state, state_nxt;
    logic       byte_ready, byte_valid;
    logic [7:0] byte_data;
    logic       ld_opcode, ld_op1, ld_op2, exec;
    logic [7:0] opcode, op1, op2;

    logic [5:0]        row_inc, put_row;
    logic [6:0]        put_col;
    logic [ADDR_W-1:0] cur_addr;
    logic              cursor_ok;

    cmd_byte_reader u_reader (
        .clk        (clk),
        .nrst       (nrst),
        .cmd_avail  (cmd_avail),
        .cmd_data   (cmd_data),
        .byte_ready (byte_ready),
        .cmd_rd     (cmd_rd),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_OPCODE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OPCODE: if (byte_valid)
                state_nxt = (opnd_count(byte_data) == 2'd0) ? S_EXEC : S_OPND1;
            S_OPND1:  if (byte_valid)
                state_nxt = (opnd_count(opcode) == 2'd2) ? S_OPND2 : S_EXEC;
            S_OPND2:  if (byte_valid)
                state_nxt = S_EXEC;
            S_EXEC:   state_nxt = S_OPCODE;
            default:  state_nxt = S_OPCODE;
        endcase
    end

    always_comb begin
        byte_ready = (state != S_EXEC);
        ld_opcode  = byte_valid && (state == S_OPCODE);
        ld_op1     = byte_valid && (state == S_OPND1);
        ld_op2     = byte_valid && (state == S_OPND2);
        exec       = (state == S_EXEC);
    end

    // Command bytes are only consumed after the FSM has loaded them, so
    // they need no reset.
    always_ff @(posedge clk) begin
        if (ld_opcode) opcode <= byte_data;
        if (ld_op1)    op1    <= byte_data;
        if (ld_op2)    op2    <= byte_data;
    end

    // Cursor advance with end-of-line and end-of-screen wrap.
    always_comb begin
        row_inc   = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
        put_col   = cursor_col + 7'd1;
        put_row   = cursor_row;
        if (cursor_col == LAST_COL) begin
            put_col = 7'd0;
            put_row = row_inc;
        end
        cur_addr  = ADDR_W'(cursor_row) * ADDR_W'(TEXT_COLS) + ADDR_W'(cursor_col);
        cursor_ok = (op1 < COLS_B) && (op2 < ROWS_B);
    end

    // Execute edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bg_color   <= 12'h000;
            fg_color   <= 12'hFFF;
            cursor_col <= 7'd0;
            cursor_row <= 6'd0;
            char_wr    <= 1'b0;
            char_addr  <= '0;
            char_data  <= 8'h00;
            err_count  <= 8'h00;
        end else begin
            char_wr <= 1'b0;
            if (exec) begin
                case (opcode)
                    OP_NOP: begin
                    end
                    OP_SET_BG: bg_color <= {op1, op2[3:0]};
                    OP_SET_FG: fg_color <= {op1, op2[3:0]};
                    OP_SET_CURSOR: begin
                        if (cursor_ok) begin
                            cursor_col <= op1[6:0];
                            cursor_row <= op2[5:0];
                        end else begin
                            err_count <= sat_inc(err_count);
                        end
                    end
                    OP_PUT_CHAR: begin
                        char_wr    <= 1'b1;
                        char_data  <= op1;
                        char_addr  <= cur_addr;
                        cursor_col <= put_col;
                        cursor_row <= put_row;
                    end
                    OP_NEWLINE: begin
                        cursor_col <= 7'd0;
                        cursor_row <= row_inc;
                    end
                    default: err_count <= sat_inc(err_count);
                endcase
            end
        end
    end

endmodule
